// File: rtl/i2s_dac_tx.sv
// I2S master transmitter for a stereo DAC: derives bck/lrck from mck, double-buffers one
// stereo pair and shifts it out Philips-style (MSB one bck after each lrck edge).
module i2s_dac_tx #(
  parameter int SAMPLE_W    = 24,
  parameter int SLOT_W      = 32,
  parameter int MCK_PER_BCK = 4
) (
  input  logic                i_mck,
  input  logic                i_rst_n,
  input  logic [SAMPLE_W-1:0] i_in_l,
  input  logic [SAMPLE_W-1:0] i_in_r,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  output logic                o_bck,
  output logic                o_lrck,
  output logic                o_sdata,
  output logic                o_frame_start,
  output logic                o_underrun
);

  localparam int DIV_W = (MCK_PER_BCK > 1) ? $clog2(MCK_PER_BCK) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int PAD   = SLOT_W - SAMPLE_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCK_PER_BCK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCK_PER_BCK / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_W);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_bck, r_lrck, r_sdata, r_frame_start, r_underrun;
  logic [SAMPLE_W-1:0] r_act_l, r_act_r, r_sh_l, r_sh_r;
  logic                r_sh_full;

  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt, w_slot_pos, w_shift;
  logic [SLOT_W-1:0]   w_word_l, w_word_r, w_word_sel;
  logic                w_fall, w_load, w_accept, w_lr_nxt, w_sdata_nxt;

  always_comb begin
    w_fall    = (r_div_cnt == DIV_LAST);
    w_div_nxt = w_fall ? '0 : r_div_cnt + 1'b1;
    w_bit_nxt = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    w_load    = w_fall && (r_bit_cnt == BIT_LAST);
    w_accept  = i_in_valid && !r_sh_full;
    w_lr_nxt  = (w_bit_nxt >= SLOT);
    w_slot_pos = w_lr_nxt ? (w_bit_nxt - SLOT) : w_bit_nxt;
    w_word_l  = SLOT_W'(r_act_l) << PAD;
    w_word_r  = SLOT_W'(r_act_r) << PAD;
    w_shift   = SLOT - w_slot_pos;
    w_word_sel = (w_lr_nxt ? w_word_r : w_word_l) >> w_shift;
    // Slot position 0 still carries the LSB of the word that just ended.
    if (w_slot_pos == '0) w_sdata_nxt = w_lr_nxt ? w_word_l[0] : w_word_r[0];
    else                  w_sdata_nxt = w_word_sel[0];
  end

  always_ff @(posedge i_mck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bck     <= 1'b0;
      r_lrck    <= 1'b0;
      r_sdata   <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bck     <= (w_div_nxt >= DIV_HALF);
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_lr_nxt;
        r_sdata   <= w_sdata_nxt;
      end
    end
  end

  always_ff @(posedge i_mck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_l       <= '0;
      r_act_r       <= '0;
      r_sh_l        <= '0;
      r_sh_r        <= '0;
      r_sh_full     <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_sh_full && !i_in_valid;
      if (w_load) begin
        if (r_sh_full) begin
          r_act_l   <= r_sh_l;
          r_act_r   <= r_sh_r;
          r_sh_full <= 1'b0;
        end else if (i_in_valid) begin
          // Empty shadow at load: a pair offered right now bypasses straight to active.
          r_act_l <= i_in_l;
          r_act_r <= i_in_r;
        end
      end else if (w_accept) begin
        r_sh_l    <= i_in_l;
        r_sh_r    <= i_in_r;
        r_sh_full <= 1'b1;
      end
    end
  end

  assign o_in_ready    = !r_sh_full;
  assign o_bck         = r_bck;
  assign o_lrck        = r_lrck;
  assign o_sdata       = r_sdata;
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomised bench for i2s_dac_tx: a frame-level reference model predicts every output
// on every mck cycle from the transmitted pair, position in the frame and buffer state.
module tb_i2s_dac_tx;
  localparam int SW = 24;
  localparam int SL = 32;
  localparam int MP = 4;
  localparam int FR = 2 * SL * MP;
  localparam int NF = 12;

  logic          i_mck = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [SW-1:0] i_in_l = '0;
  logic [SW-1:0] i_in_r = '0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready, o_bck, o_lrck, o_sdata, o_frame_start, o_underrun;

  i2s_dac_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .MCK_PER_BCK(MP)) u_dut (
    .i_mck(i_mck), .i_rst_n(i_rst_n), .i_in_l(i_in_l), .i_in_r(i_in_r),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_bck(o_bck), .o_lrck(o_lrck),
    .o_sdata(o_sdata), .o_frame_start(o_frame_start), .o_underrun(o_underrun)
  );

  always #5 i_mck = ~i_mck;

  int n_pass = 0;
  int n_total = 0;

  // model state: n = mck edges since reset release
  int            n;
  int            epoch;
  logic          m_full, m_fs, m_uf;
  logic [SW-1:0] m_sh_l, m_sh_r, m_act_l, m_act_r, m_prev_r;
  logic [SW-1:0] ql[$];
  logic [SW-1:0] qr[$];
  int            r_off[NF];
  int            r_cnt[NF];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
  endtask

  function automatic logic wbit(input logic [SW-1:0] smp, input int s);
    logic [SL-1:0] w;
    logic [SL-1:0] t;
    w = SL'(smp) << (SL - SW);
    t = w >> (SL - s);
    return t[0];
  endfunction

  function automatic logic exp_sdata();
    int b = (n / MP) % (2 * SL);
    int s = b % SL;
    bit right = (b >= SL);
    if (s == 0) return right ? wbit(m_act_l, SL) : wbit(m_prev_r, SL);
    return wbit(right ? m_act_r : m_act_l, s);
  endfunction

  task automatic model_reset();
    n = 0;
    m_full = 0; m_fs = 0; m_uf = 0;
    m_sh_l = '0; m_sh_r = '0; m_act_l = '0; m_act_r = '0; m_prev_r = '0;
    ql.delete();
    qr.delete();
  endtask

  task automatic check_all();
    chk("bck",         32'(o_bck),         32'((n % MP) >= MP / 2));
    chk("lrck",        32'(o_lrck),        32'(((n / MP) % (2 * SL)) >= SL));
    chk("sdata",       32'(o_sdata),       32'(exp_sdata()));
    chk("in_ready",    32'(o_in_ready),    32'(!m_full));
    chk("frame_start", 32'(o_frame_start), 32'(m_fs));
    chk("underrun",    32'(o_underrun),    32'(m_uf));
  endtask

  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
    ql.push_back(l);
    qr.push_back(r);
  endtask

  task automatic schedule();
    int f = n / FR;
    int o = n % FR;
    if (epoch == 0) begin
      if (f == 0 && o == 20) push(24'hBFFFFF, 24'h3FFFFF);
      if (f == 1 && o == 40) push(24'h800000, 24'h7FFFFF);
      if (f == 3 && o == 30) begin
        push(SW'($urandom), SW'($urandom));
        push(SW'($urandom), SW'($urandom));
      end
      if (f == 5 && o == FR - 1) push(SW'($urandom), SW'($urandom));
      if (f >= 6 && f < NF && o == r_off[f])
        for (int k = 0; k < r_cnt[f]; k++) push(SW'($urandom), SW'($urandom));
    end else if (f == 0 && o == 10) begin
      push(SW'($urandom), SW'($urandom));
    end
  endtask

  // check state after edge n, drive inputs for edge n+1, advance the model to n+1
  task automatic cycle();
    bit load, acc;
    check_all();
    schedule();
    i_in_valid = (ql.size() > 0);
    if (i_in_valid) begin
      i_in_l = ql[0];
      i_in_r = qr[0];
    end else begin
      i_in_l = SW'($urandom);
      i_in_r = SW'($urandom);
    end
    load = ((n + 1) % FR == 0);
    acc  = i_in_valid && !m_full;
    m_fs = 0;
    m_uf = 0;
    if (load) begin
      m_fs = 1;
      m_prev_r = m_act_r;
      if (m_full) begin
        m_act_l = m_sh_l; m_act_r = m_sh_r; m_full = 0;
      end else if (i_in_valid) begin
        m_act_l = i_in_l; m_act_r = i_in_r;
      end else begin
        m_uf = 1;
      end
    end else if (acc) begin
      m_sh_l = i_in_l; m_sh_r = i_in_r; m_full = 1;
    end
    if (acc) begin
      void'(ql.pop_front());
      void'(qr.pop_front());
    end
    n++;
    @(negedge i_mck);
  endtask

  initial begin
    for (int i = 0; i < NF; i++) begin
      r_off[i] = $urandom_range(FR - 1);
      r_cnt[i] = $urandom_range(2);
    end
    epoch = 0;
    model_reset();
    repeat (6) begin
      @(negedge i_mck);
      i_in_valid = 1'($urandom_range(1));
      i_in_l = SW'($urandom);
      i_in_r = SW'($urandom);
      check_all();
    end
    @(negedge i_mck);
    i_rst_n = 1'b1;
    repeat (NF * FR + 50) cycle();

    // asynchronous reset in the middle of the left slot
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    epoch = 1;
    check_all();
    repeat (3) begin
      @(negedge i_mck);
      check_all();
    end
    i_rst_n = 1'b1;
    repeat (2 * FR + 20) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
